// File: rtl/matsrv_pkg.sv
// Shared defaults and types for the matrix operand server.
package matsrv_pkg;

  localparam int N_DEF  = 32;
  localparam int W_DEF  = 8;
  localparam int IW_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SERVE  = 2'd2
  } matsrv_state_t;

  typedef logic [N_DEF-1:0][W_DEF-1:0] line_t;

endpackage

// File: rtl/matrix_line_store.sv
// N-word line memory: byte-lane write port plus one registered full-word read port.
module matrix_line_store #(
  parameter int N  = 32,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IW-1:0]         waddr_i,
  input  logic [IW-1:0]         wlane_i,
  input  logic [W-1:0]          wdata_i,
  input  logic                  re_i,
  input  logic [IW-1:0]         raddr_i,
  output logic [N-1:0][W-1:0]   rdata_o
);

  // Storage is deliberately not reset; only the read register is.
  logic [N-1:0][W-1:0] mem_q [N];
  logic [N-1:0][W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i][wlane_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/matrix_operand_server.sv
// Loads A row-major and B column-major from a byte stream, then serves row/column requests.
// Optional overrun counter enabled by defining MATSRV_OVERRUN_CNT_EN.
module matrix_operand_server
  import matsrv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [W-1:0]          load_data,
  input  logic                  load_valid,
  input  logic                  alg_done,
  input  logic [IW-1:0]         row_req,
  input  logic [IW-1:0]         col_req,
  output logic                  complete,
  output logic [N-1:0][W-1:0]   matA_row,
  output logic [N-1:0][W-1:0]   matB_col,
  output logic [IW-1:0]         row_in,
  output logic [IW-1:0]         col_in,
  output logic                  val_rows,
`ifdef MATSRV_OVERRUN_CNT_EN
  output logic [15:0]           overrun_cnt,
`endif
  output logic [1:0]            state_dbg,
  output logic [2*IW-1:0]       load_cnt_dbg
);

  localparam int CW = 2 * IW;
  localparam logic [CW-1:0] CNT_LAST = CW'(N * N - 1);

  matsrv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            alg_q, complete_q, val_q, first_q;
  logic [IW-1:0]   row_q, col_q;
  logic            alg_rise, serve_act, cnt_wrap, we_a, we_b;

  assign alg_rise  = alg_done & ~alg_q;
  assign serve_act = (state_q == SERVE) && !alg_rise;
  assign cnt_wrap  = (cnt_q == CNT_LAST);
  assign we_a      = load_valid && (state_q == LOAD_A);
  assign we_b      = load_valid && (state_q == LOAD_B);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_A: if (load_valid) begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        if (cnt_wrap) state_d = LOAD_B;
      end
      LOAD_B: if (load_valid) begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        if (cnt_wrap) state_d = SERVE;
      end
      SERVE: if (alg_rise) begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
      default: state_d = LOAD_A;
    endcase
  end

  // row_q/col_q double as the last served pair for request dedup.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      alg_q      <= 1'b0;
      complete_q <= 1'b0;
      val_q      <= 1'b0;
      first_q    <= 1'b1;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alg_q      <= alg_done;
      complete_q <= (state_d == SERVE);
      first_q    <= (state_q != SERVE);
      if (serve_act) begin
        val_q <= first_q || (row_req != row_q) || (col_req != col_q);
        row_q <= row_req;
        col_q <= col_req;
      end else begin
        val_q <= 1'b0;
      end
    end
  end

  // Row-major A and column-major B share the same word/lane split of the counter.
  matrix_line_store #(.N(N), .W(W), .IW(IW)) u_store_a (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .we_i    (we_a),
    .waddr_i (cnt_q[CW-1:IW]),
    .wlane_i (cnt_q[IW-1:0]),
    .wdata_i (load_data),
    .re_i    (serve_act),
    .raddr_i (row_req),
    .rdata_o (matA_row)
  );

  matrix_line_store #(.N(N), .W(W), .IW(IW)) u_store_b (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .we_i    (we_b),
    .waddr_i (cnt_q[CW-1:IW]),
    .wlane_i (cnt_q[IW-1:0]),
    .wdata_i (load_data),
    .re_i    (serve_act),
    .raddr_i (col_req),
    .rdata_o (matB_col)
  );

`ifdef MATSRV_OVERRUN_CNT_EN
  logic [15:0] ovr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) ovr_q <= '0;
    else if (load_valid && (state_q == SERVE) && (ovr_q != 16'hFFFF)) ovr_q <= ovr_q + 16'd1;
  end

  assign overrun_cnt = ovr_q;
`endif

  assign complete     = complete_q;
  assign val_rows     = val_q;
  assign row_in       = row_q;
  assign col_in       = col_q;
  assign state_dbg    = state_q;
  assign load_cnt_dbg = cnt_q;

endmodule

// File: tb/tb_matrix_operand_server.sv
// Self-checking bench for matrix_operand_server: table vectors, full sweep, random requests.
module tb_matrix_operand_server;

  localparam int N  = 32;
  localparam int W  = 8;
  localparam int IW = 5;
  localparam int LW = N * W;
  localparam int NN = N * N;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic [W-1:0]        load_data;
  logic                load_valid;
  logic                alg_done;
  logic [IW-1:0]       row_req;
  logic [IW-1:0]       col_req;
  logic                complete;
  logic [N-1:0][W-1:0] matA_row;
  logic [N-1:0][W-1:0] matB_col;
  logic [IW-1:0]       row_in;
  logic [IW-1:0]       col_in;
  logic                val_rows;
  logic [15:0]         overrun_cnt;
  logic [1:0]          state_dbg;
  logic [2*IW-1:0]     load_cnt_dbg;

`ifndef MATSRV_OVERRUN_CNT_EN
  assign overrun_cnt = 16'd0;
`endif

  matrix_operand_server #(.N(N), .W(W), .IW(IW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .alg_done     (alg_done),
    .row_req      (row_req),
    .col_req      (col_req),
    .complete     (complete),
    .matA_row     (matA_row),
    .matB_col     (matB_col),
    .row_in       (row_in),
    .col_in       (col_in),
    .val_rows     (val_rows),
`ifdef MATSRV_OVERRUN_CNT_EN
    .overrun_cnt  (overrun_cnt),
`endif
    .state_dbg    (state_dbg),
    .load_cnt_dbg (load_cnt_dbg)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: matrix contents plus last-served pair
  logic [W-1:0]  a_m [N][N];
  logic [W-1:0]  b_m [N][N];
  logic [LW-1:0] exp_q [$];
  logic          have_last;
  logic [IW-1:0] last_r, last_c;
  int            n_cmp = 0;
  int            n_bad = 0;

  typedef struct {
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          v;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [LW-1:0] a_row_vec(input int r);
    logic [LW-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = a_m[r][c];
    return v;
  endfunction

  function automatic logic [LW-1:0] b_col_vec(input int c);
    logic [LW-1:0] v;
    for (int r = 0; r < N; r++) v[r*W +: W] = b_m[r][c];
    return v;
  endfunction

  // Driver: A stream row-major, then B stream column-major, with random idle gaps
  task automatic load_all();
    for (int k = 0; k < 2 * NN; k++) begin
      int j;
      j = k % NN;
      if ($urandom_range(0, 7) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_data  = (k < NN) ? a_m[j / N][j % N] : b_m[j % N][j / N];
      if (k == NN) chk("state_load_b", LW'(state_dbg), LW'(1));
      if (k == 2 * NN - 1) chk("complete_before_last", LW'(complete), LW'(0));
      tick();
    end
    load_valid = 1'b0;
    load_data  = '0;
    chk("complete_after_last", LW'(complete), LW'(1));
    chk("state_serve", LW'(state_dbg), LW'(2));
    have_last = 1'b0;
  endtask

  // One request cycle; expected val_rows from the table when use_tbl, else from the dedup rule
  task automatic req(input logic [IW-1:0] r, input logic [IW-1:0] c, input string tag,
                     input bit use_tbl, input logic tbl_v);
    logic exp_v;
    row_req = r;
    col_req = c;
    exp_v = use_tbl ? tbl_v : (!have_last || r != last_r || c != last_c);
    have_last = 1'b1;
    last_r = r;
    last_c = c;
    exp_q.push_back(a_row_vec(r));
    exp_q.push_back(b_col_vec(c));
    tick();
    chk({tag, "_val"}, LW'(val_rows), LW'(exp_v));
    chk({tag, "_row"}, LW'(row_in), LW'(r));
    chk({tag, "_col"}, LW'(col_in), LW'(c));
    chk({tag, "_a"}, matA_row, exp_q.pop_front());
    chk({tag, "_b"}, matB_col, exp_q.pop_front());
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_complete"}, LW'(complete), LW'(0));
    chk({tag, "_val"}, LW'(val_rows), LW'(0));
    chk({tag, "_row_in"}, LW'(row_in), LW'(0));
    chk({tag, "_col_in"}, LW'(col_in), LW'(0));
    chk({tag, "_mat_a"}, matA_row, '0);
    chk({tag, "_mat_b"}, matB_col, '0);
    chk({tag, "_state"}, LW'(state_dbg), LW'(0));
    chk({tag, "_cnt"}, LW'(load_cnt_dbg), LW'(0));
`ifdef MATSRV_OVERRUN_CNT_EN
    chk({tag, "_overrun"}, LW'(overrun_cnt), LW'(0));
`endif
  endtask

  initial begin
    int perm [NN];
    int seen [NN];
    int n_val;
    logic [IW-1:0] pr, pc;

    rst_in = 1'b1; load_data = '0; load_valid = 1'b0; alg_done = 1'b0;
    row_req = '0; col_req = '0; have_last = 1'b0; last_r = '0; last_c = '0;
    tick(); tick();
    chk_reset_state("reset");
    rst_in = 1'b0;

    // Pattern load: A(r,c)=r+c, B(r,c)=r^c
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = W'(r + c);
        b_m[r][c] = W'(r ^ c);
      end
    load_all();

    // First request in SERVE, with hand-computed lane values
    req(5'd3, 5'd7, "first", 1'b1, 1'b1);
    chk("lane_a5", LW'(matA_row[5]), LW'(8));
    chk("lane_b2", LW'(matB_col[2]), LW'(5));

    // Held request plus a few changes
    tbl[0] = '{r: 5'd3,  c: 5'd7,  v: 1'b0};
    tbl[1] = '{r: 5'd3,  c: 5'd7,  v: 1'b0};
    tbl[2] = '{r: 5'd3,  c: 5'd7,  v: 1'b0};
    tbl[3] = '{r: 5'd3,  c: 5'd7,  v: 1'b0};
    tbl[4] = '{r: 5'd4,  c: 5'd7,  v: 1'b1};
    tbl[5] = '{r: 5'd4,  c: 5'd8,  v: 1'b1};
    tbl[6] = '{r: 5'd4,  c: 5'd8,  v: 1'b0};
    tbl[7] = '{r: 5'd31, c: 5'd0,  v: 1'b1};
    for (int i = 0; i < 8; i++) req(tbl[i].r, tbl[i].c, $sformatf("tbl%0d", i), 1'b1, tbl[i].v);

    // Full sweep in shuffled order; every pair must be answered exactly once
    for (int i = 0; i < NN; i++) begin perm[i] = i; seen[i] = 0; end
    for (int i = NN - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    if (perm[0] == 31 * N) begin perm[0] = perm[1]; perm[1] = 31 * N; end
    n_val = 0;
    for (int i = 0; i < NN; i++) begin
      req(IW'(perm[i] / N), IW'(perm[i] % N), "sweep", 1'b0, 1'b0);
      if (val_rows) begin
        seen[int'(row_in) * N + int'(col_in)]++;
        n_val++;
      end
    end
    chk("sweep_responses", LW'(n_val), LW'(NN));
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < NN; i++) if (seen[i] != 1) bad++;
      chk("sweep_coverage", LW'(bad), LW'(0));
    end

    // Random requests with frequent repeats
    pr = '0; pc = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        pr = IW'($urandom_range(0, N - 1));
        pc = IW'($urandom_range(0, N - 1));
      end
      req(pr, pc, "rand", 1'b0, 1'b0);
    end

    // Bytes during SERVE, alg_done rising with the third one
    load_valid = 1'b1; load_data = 8'hAA; alg_done = 1'b0;
    tick(); tick();
    chk("alg_still_complete", LW'(complete), LW'(1));
`ifdef MATSRV_OVERRUN_CNT_EN
    chk("overrun_two", LW'(overrun_cnt), LW'(2));
`endif
    alg_done = 1'b1;
    tick();
    load_valid = 1'b0; alg_done = 1'b0;
    chk("alg_complete_drop", LW'(complete), LW'(0));
    chk("alg_val_drop", LW'(val_rows), LW'(0));
    chk("alg_state", LW'(state_dbg), LW'(0));
    chk("alg_cnt", LW'(load_cnt_dbg), LW'(0));
`ifdef MATSRV_OVERRUN_CNT_EN
    chk("overrun_three", LW'(overrun_cnt), LW'(3));
`endif
    tick();
    chk("alg_cnt_idle", LW'(load_cnt_dbg), LW'(0));

    // Partial A load interrupted by reset
    for (int i = 0; i < 500; i++) begin
      load_valid = 1'b1;
      load_data  = W'($urandom);
      tick();
    end
    load_valid = 1'b0;
    chk("partial_cnt", LW'(load_cnt_dbg), LW'(500));
    chk("partial_state", LW'(state_dbg), LW'(0));
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk_reset_state("mid_reset");

    // Fresh random contents after reset
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r][c] = W'($urandom);
        b_m[r][c] = W'($urandom);
      end
    load_all();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        pr = IW'($urandom_range(0, N - 1));
        pc = IW'($urandom_range(0, N - 1));
      end
      req(pr, pc, "reload", 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matrix_operand_server.md
# matrix_operand_server

Responder side of the matrix-algorithm operand interface. Loads matrix A row-major and matrix B column-major from a byte stream, then raises `complete`. After that it serves row/column requests from the algorithm block by returning a full A row, a full B column, the echoed coordinates and a `val_rows` strobe. It sits between the host byte loader (UART/loader path) and the matrix algorithm core.

## Interface
Parameters:
- `N`, default 32: matrix dimension, square N×N.
- `W`, default 8: element width in bits.
- `IW`, default $clog2(N) = 5: index width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous active-high reset.
- `load_data`  in  W  incoming matrix byte.
- `load_valid`  in  1  `load_data` valid this cycle.
- `alg_done`  in  1  algorithm finished (level); rising edge ends the serve phase.
- `row_req`  in  IW  requested A row.
- `col_req`  in  IW  requested B column.
- `complete`  out  1  both matrices loaded; level while serving.
- `matA_row`  out  N×W, packed [N-1:0][W-1:0]  lane c = A(row_in, c).
- `matB_col`  out  N×W, packed [N-1:0][W-1:0]  lane r = B(r, col_in).
- `row_in`  out  IW  row coordinate of the current response.
- `col_in`  out  IW  column coordinate of the current response.
- `val_rows`  out  1  response valid strobe.
- `overrun_cnt`  out  16  bytes dropped during serve. Present only with `MATSRV_OVERRUN_CNT_EN`.

## Operation
States:
- `LOAD_A`: each `load_valid` byte k, for k = 0..N²-1, is written to A(k/N, k%N). Lane-enable write into row word k/N.
- `LOAD_B`: byte k = 0..N²-1 is written to B(k%N, k/N), so the stream is column-major. Lane k%N of column word k/N.
- `SERVE`: requests are answered; load bytes are ignored.

Transitions:
- `LOAD_A`→`LOAD_B` on the write of byte N²-1.
- `LOAD_B`→`SERVE` on the write of byte N²-1. `complete` rises the next cycle.
- `SERVE`→`LOAD_A` on a rising edge of `alg_done` (registered `alg_done` history). The load counter clears, `complete` and `val_rows` drop the next cycle, and A/B contents are retained until overwritten.

Load counter:
- log2(N²)-bit counter, wraps to 0 at each matrix boundary.
- `load_valid` with `alg_done` rising in the same cycle in `SERVE`: the byte is dropped, the transition is taken.

Serving, every cycle in `SERVE`:
- Register A[`row_req`], B[`col_req`], `row_in`←`row_req`, `col_in`←`col_req`.
- `val_rows` is 1 iff (`row_req`,`col_req`) differs from the last served pair, or this is the first cycle in `SERVE`. This dedups a requester that holds its request until it sees a response.
- Out-of-range indices cannot occur because IW is sized exactly to N.

Reset:
- `complete`, `val_rows`, `row_in`, `col_in` = 0; `matA_row`, `matB_col` = 0; state `LOAD_A`; counter 0; `overrun_cnt` = 0.
- Storage is not cleared.
- Reset mid-load discards partial progress.

## Timing
- Load write: 1 byte/cycle max, no backpressure.
- `complete`: 1 cycle after the last B byte is accepted.
- Response latency: request sampled at edge t, data/coords/`val_rows` valid after edge t+1 (1 cycle, registered).
- Back-to-back new requests: one response per cycle.
- `val_rows` is a 1-cycle strobe per distinct request.

## Configuration
- `MATSRV_OVERRUN_CNT_EN` defined: `overrun_cnt` port and a 16-bit saturating counter (holds at 0xFFFF). It increments on each `load_valid` in `SERVE`, and clears only on reset.
- Undefined: port and counter absent; dropped bytes are silently ignored.

## Structure
- Package `matsrv_pkg`: `N`, `W`, `IW` defaults; state enum `matsrv_state_t {LOAD_A, LOAD_B, SERVE}`; `line_t` = logic [N-1:0][W-1:0].
- Sub-module `matrix_line_store`: N words of `line_t`, one byte-lane write port (word address, lane, data, enable) and one registered full-word read port. Instantiated twice, once for A and once for B.

## Test plan
- Load A(r,c)=r+c, B(r,c)=r^c, then request (3,7) → one cycle later `matA_row[5]`=8, `matB_col[2]`=5, `row_in`=3, `col_in`=7, `val_rows`=1.
- Hold (3,7) for 5 cycles → `val_rows` high only on the first response.
- Drive the dummy algorithm requester over the full sweep → 1024 responses, each coordinate pair exactly once, values match the model.
- Assert `rst_in` after 500 A bytes, then load 2048 fresh bytes → `complete` rises exactly 1 cycle after byte 2048.
- In `SERVE`, pulse `alg_done` with `load_valid` high for 3 cycles → `complete`=0, state `LOAD_A`, counter 0, and (with `MATSRV_OVERRUN_CNT_EN`) `overrun_cnt`=3.
- Build without `MATSRV_OVERRUN_CNT_EN` → port absent, all other scenarios pass unchanged.
